// File: rtl/shifter.sv
// Parallel-load serialiser. A write captures a word; bits then leave one per
// clock on out, MSB first by default, LSB first when SHIFTER_LSB_FIRST_EN is defined.
module shifter #(
    parameter int WIDTH = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           write,
    input  logic [WIDTH:0] data,
    output logic           out,
    output logic           empty
);

    localparam int             POS_W = $clog2(WIDTH + 2);
    localparam logic [POS_W-1:0] FULL  = POS_W'(WIDTH + 1);

    logic [WIDTH:0]   buffer;
    logic [POS_W-1:0] position;
    logic [WIDTH:0]   buffer_d;
    logic [POS_W-1:0] position_d;

    // A write always wins, so a new word aborts whatever was still being sent.
    always_comb begin
        buffer_d   = buffer;
        position_d = position;
        if (write) begin
            buffer_d   = data;
            position_d = FULL;
        end else if (position != '0) begin
`ifdef SHIFTER_LSB_FIRST_EN
            buffer_d   = {1'b0, buffer[WIDTH:1]};
`else
            buffer_d   = {buffer[WIDTH-1:0], 1'b0};
`endif
            position_d = position - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buffer   <= '0;
            position <= '0;
        end else begin
            buffer   <= buffer_d;
            position <= position_d;
        end
    end

    assign empty = (position == '0);

`ifdef SHIFTER_LSB_FIRST_EN
    assign out = empty ? 1'b0 : buffer[0];
`else
    assign out = empty ? 1'b0 : buffer[WIDTH];
`endif

endmodule

// File: tb/tb_shifter.sv
// Directed bench for shifter (WIDTH=7); follows SHIFTER_LSB_FIRST_EN for bit order.
module tb_shifter;

  logic       clk;
  logic       reset;
  logic       write;
  logic [7:0] data;
  logic       out;
  logic       empty;

  int vectors = 0;
  int miscompares = 0;

  shifter #(.WIDTH(7)) dut (
    .clk   (clk),
    .reset (reset),
    .write (write),
    .data  (data),
    .out   (out),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    write = 1'b1;
    data  = d;
    step();
    write = 1'b0;
  endtask

  // seq[7] is the first bit expected on out, seq[0] the last.
  task automatic expect_seq(input string tag, input logic [7:0] seq);
    for (int i = 7; i >= 0; i--) begin
      check({tag, "_out"}, {31'b0, out}, {31'b0, seq[i]});
      check({tag, "_busy"}, {31'b0, empty}, 32'd0);
      step();
    end
    check({tag, "_empty_end"}, {31'b0, empty}, 32'd1);
    check({tag, "_out_end"}, {31'b0, out}, 32'd0);
    check({tag, "_pos_end"}, {28'b0, dut.position}, 32'd0);
    check({tag, "_buf_end"}, {24'b0, dut.buffer}, 32'd0);
  endtask

  logic [7:0] seq_c1;
  logic [7:0] seq_aa_first2;

  initial begin
`ifdef SHIFTER_LSB_FIRST_EN
    seq_c1        = 8'b1000_0011;
    seq_aa_first2 = 8'b0101_0101;
`else
    seq_c1        = 8'b1100_0001;
    seq_aa_first2 = 8'b1010_1010;
`endif

    // Reset held with active inputs: state must stay cleared.
    reset = 1'b0;
    write = 1'b1;
    data  = 8'hFF;
    step();
    step();
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_out", {31'b0, out}, 32'd0);
    check("rst_buf", {24'b0, dut.buffer}, 32'h00);
    check("rst_pos", {28'b0, dut.position}, 32'd0);
    write = 1'b0;
    data  = 8'h00;
    step();
    reset = 1'b1;
    step();
    check("idle_empty", {31'b0, empty}, 32'd1);

    // Single-edge load of 0xC1.
    load(8'hC1);
    check("c1_pos_load", {28'b0, dut.position}, 32'd8);
    check("c1_buf_load", {24'b0, dut.buffer}, 32'hC1);
    expect_seq("c1", seq_c1);
    step();
    check("hold_empty", {31'b0, empty}, 32'd1);
    check("hold_pos", {28'b0, dut.position}, 32'd0);

    // Write held for two edges: reloads, no shifting until write drops.
    write = 1'b1;
    data  = 8'hC1;
    step();
    check("hold2_pos_a", {28'b0, dut.position}, 32'd8);
    step();
    check("hold2_pos_b", {28'b0, dut.position}, 32'd8);
    check("hold2_buf_b", {24'b0, dut.buffer}, 32'hC1);
    write = 1'b0;
    expect_seq("hold2", seq_c1);

    // Reload mid-shift: 0xFF, three shifts, then 0x00.
    load(8'hFF);
    for (int i = 0; i < 3; i++) begin
      check("ff_out", {31'b0, out}, 32'd1);
      step();
    end
    check("ff_pos_after3", {28'b0, dut.position}, 32'd5);
    load(8'h00);
    check("reload_pos", {28'b0, dut.position}, 32'd8);
    expect_seq("reload00", 8'h00);

    // Reset mid-shift: 0xAA, two shifts, then asynchronous reset.
    load(8'hAA);
    check("aa_bit0", {31'b0, out}, {31'b0, seq_aa_first2[7]});
    step();
    check("aa_bit1", {31'b0, out}, {31'b0, seq_aa_first2[6]});
    step();
    check("aa_pos", {28'b0, dut.position}, 32'd6);
    #2;
    reset = 1'b0;
    #1;
    check("mrst_empty", {31'b0, empty}, 32'd1);
    check("mrst_out", {31'b0, out}, 32'd0);
    check("mrst_pos", {28'b0, dut.position}, 32'd0);
    check("mrst_buf", {24'b0, dut.buffer}, 32'h00);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_empty", {31'b0, empty}, 32'd1);
      check("post_rst_out", {31'b0, out}, 32'd0);
    end

    // Fresh load after reset still works.
    load(8'hC1);
    expect_seq("c1_again", seq_c1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shifter.md
SHIFTER -- requirements
Module: shifter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 7, the MSB index of the load word (word is WIDTH+1 bits).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 The module SHALL have port write, input, 1 bit, the parallel-load strobe, sampled on rising clk.
REQ-005 The module SHALL have port data, input, WIDTH+1 bits, the parallel word loaded on write.
REQ-006 The module SHALL have port out, output, 1 bit, the current serial bit.
REQ-007 The module SHALL have port empty, output, 1 bit, high when no unsent bits remain.

Function
REQ-008 The module SHALL hold internal registers named buffer (WIDTH+1 bits) and position (remaining-bit count, $clog2(WIDTH+2) bits); benches probe them hierarchically.
REQ-009 On a rising edge with write=1, the module SHALL set buffer<=data and position<=WIDTH+1, regardless of current state (a load in progress is aborted).
REQ-010 On a rising edge with write=0 and position>0, the module SHALL shift buffer left by one (zero fill) and decrement position.
REQ-011 On a rising edge with write=0 and position=0, the module SHALL hold all state.
REQ-012 empty SHALL be combinational: 1 iff position==0.
REQ-013 out SHALL be combinational: buffer[WIDTH] when position>0, else 0.
REQ-014 Latency: the first bit (data[WIDTH]) SHALL appear on out immediately after the load edge; each following edge presents the next lower bit; empty SHALL rise after exactly WIDTH+1 edges with write=0 following the load edge.
REQ-015 With write held high for N edges, the module SHALL reload each edge; shifting begins on the first edge with write=0.
REQ-016 X/undriven write SHALL NOT be required to be handled; the bench drives write to a known value before reset release.

Reset
REQ-017 While reset=0, the module SHALL asynchronously force buffer=0 and position=0, giving empty=1 and out=0.
REQ-018 Reset asserted mid-transmission SHALL discard remaining bits; after release the module SHALL be idle until the next write.

Configuration
REQ-019 With macro SHIFTER_LSB_FIRST_EN defined, the module SHALL transmit LSB first: out=buffer[0], shift right with zero fill; all timing identical.
REQ-020 Without SHIFTER_LSB_FIRST_EN, the module SHALL transmit MSB first as in REQ-010/REQ-013.

Structure
REQ-021 No shared package SHALL be required; the position width SHALL be a localparam derived from WIDTH.
REQ-022 The module SHALL be a single flat module with no sub-modules.

Verification
REQ-023 Reset: reset=0 with any inputs -> empty=1, out=0, buffer=0x00, position=0, asynchronously.
REQ-024 Load 0xC1 (WIDTH=7), write pulsed one edge -> out sequence 1,1,0,0,0,0,0,1 on successive cycles, then empty=1, out=0 after the 8th shift edge.
REQ-025 write held high across two edges with data=0xC1 -> position remains 8 until write falls, then 8-bit sequence as above.
REQ-026 Reload mid-shift: load 0xFF, after 3 shifts load 0x00 -> position=8, out=0 for 8 cycles, then empty=1.
REQ-027 Reset mid-shift: load 0xAA, after 2 shifts assert reset -> immediate empty=1, out=0; no output resumes after release.
REQ-028 With SHIFTER_LSB_FIRST_EN, load 0xC1 -> out sequence 1,0,0,0,0,0,1,1.
